// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one unified instruction/data memory between the
// CPU control path (cpu_*) and a program loader/debug port (ldr_*).
//
// Ports:
//   CLK, RST       clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata -> cpu_ack, cpu_rdata, cpu_stall (comb)
//   ldr_req/we/addr/wdata -> ldr_ack, ldr_rdata
//   mem_en/we/addr/wdata  -> memory, mem_rdata <- memory
//
// Parameters: ADDR_W, DATA_W, WAIT_CYC (1..15 access cycles per transaction).
// Each winner gets one transaction: IDLE -> ACCESS (WAIT_CYC cycles)
// -> RESP (one-cycle ack) -> IDLE.
// Build option ARB_ROUND_ROBIN_EN: round-robin on ties, with the CPU
// winning the first tie after reset. If it is undefined, the loader
// always has priority.
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int WAIT_CYC = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_ack,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYC - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [3:0]        r_cnt;
    logic              r_gnt;       // 1 = loader owns the transaction
    logic              r_cpu_ack;
    logic              r_ldr_ack;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_ldr_rdata;
    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              w_any;
    logic              w_pick_ldr;

    assign w_any = cpu_req | ldr_req;

`ifdef ARB_ROUND_ROBIN_EN
    logic r_last;               // 1 = loader was granted last

    // On a tie, serve whoever was not granted last.
    assign w_pick_ldr = ldr_req & (~cpu_req | ~r_last);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_last <= 1'b1;
        end else if (r_state == IDLE && w_any) begin
            r_last <= w_pick_ldr;
        end
    end
`else
    assign w_pick_ldr = ldr_req;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_any) w_next = ACCESS;
            ACCESS:  if (r_cnt == 4'd0) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Memory outputs are registered, so they only move on the
    // IDLE->ACCESS and ACCESS->RESP edges.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt       <= '0;
            r_gnt       <= 1'b0;
            r_cpu_ack   <= 1'b0;
            r_ldr_ack   <= 1'b0;
            r_cpu_rdata <= '0;
            r_ldr_rdata <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_cpu_ack <= 1'b0;
            r_ldr_ack <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_gnt       <= w_pick_ldr;
                        r_cnt       <= CNT_LOAD;
                        r_mem_en    <= 1'b1;
                        r_mem_we    <= w_pick_ldr ? ldr_we    : cpu_we;
                        r_mem_addr  <= w_pick_ldr ? ldr_addr  : cpu_addr;
                        r_mem_wdata <= w_pick_ldr ? ldr_wdata : cpu_wdata;
                    end
                end
                ACCESS: begin
                    if (r_cnt == 4'd0) begin
                        r_mem_en  <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_cpu_ack <= ~r_gnt;
                        r_ldr_ack <= r_gnt;
                        if (!r_mem_we) begin
                            if (r_gnt) r_ldr_rdata <= mem_rdata;
                            else       r_cpu_rdata <= mem_rdata;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cpu_ack   = r_cpu_ack;
    assign ldr_ack   = r_ldr_ack;
    assign cpu_rdata = r_cpu_rdata;
    assign ldr_rdata = r_ldr_rdata;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

    // Freezes the multicycle controller until the ack cycle.
    assign cpu_stall = cpu_req & ~r_cpu_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter.
// Main DUT at WAIT_CYC=2, second instance at WAIT_CYC=15.
module tb_mem_port_arbiter;

    localparam int WC = 2;

    logic        CLK = 1'b0;
    logic        RST;
    logic        cpu_req, cpu_we, cpu_ack, cpu_stall;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        ldr_req, ldr_we, ldr_ack;
    logic [31:0] ldr_addr, ldr_wdata, ldr_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic        d15_cpu_req, d15_cpu_ack, d15_cpu_stall;
    logic [31:0] d15_cpu_addr, d15_cpu_wdata, d15_cpu_rdata;
    logic        d15_ldr_ack, d15_mem_en, d15_mem_we;
    logic [31:0] d15_ldr_rdata, d15_mem_addr, d15_mem_wdata, d15_mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;
    int cpu_acks = 0;
    int ldr_acks = 0;

    typedef struct {
        logic        ldr;
        logic [31:0] d;
    } exp_t;
    exp_t sb[$];

    logic [31:0] tbmem [0:255];

    always #5 CLK = ~CLK;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYC(WC)) u_dut (
        .CLK(CLK), .RST(RST),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr),
        .ldr_wdata(ldr_wdata), .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYC(15)) u_d15 (
        .CLK(CLK), .RST(RST),
        .cpu_req(d15_cpu_req), .cpu_we(1'b0), .cpu_addr(d15_cpu_addr),
        .cpu_wdata(d15_cpu_wdata), .cpu_ack(d15_cpu_ack),
        .cpu_rdata(d15_cpu_rdata), .cpu_stall(d15_cpu_stall),
        .ldr_req(1'b0), .ldr_we(1'b0), .ldr_addr(32'h0),
        .ldr_wdata(32'h0), .ldr_ack(d15_ldr_ack), .ldr_rdata(d15_ldr_rdata),
        .mem_en(d15_mem_en), .mem_we(d15_mem_we), .mem_addr(d15_mem_addr),
        .mem_wdata(d15_mem_wdata), .mem_rdata(d15_mem_rdata)
    );

    // Memory model: fixed contents loaded during reset; 0x20 is only
    // ever written by the loader.
    always @(posedge CLK) begin
        if (RST) begin
            tbmem[8'h10] <= 32'hDEADBEEF;
            tbmem[8'h30] <= 32'hA1A1A1A1;
            tbmem[8'h34] <= 32'hB2B2B2B2;
            tbmem[8'h38] <= 32'hC3C3C3C3;
            tbmem[8'hFC] <= 32'hBAD0BAD0;
        end else if (mem_en && mem_we) begin
            tbmem[mem_addr[7:0]] <= mem_wdata;
        end
    end

    assign mem_rdata = mem_en ? tbmem[mem_addr[7:0]] : 32'h0;

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    task automatic expect_ack(logic l, logic [31:0] d);
        exp_t e;
        e.ldr = l;
        e.d   = d;
        sb.push_back(e);
    endtask

    // Monitor: every ack pops the oldest expectation.
    always @(negedge CLK) begin
        if (!RST && (cpu_ack || ldr_ack)) begin
            if (cpu_ack) cpu_acks++;
            if (ldr_ack) ldr_acks++;
            n_tests++;
            if (cpu_ack && ldr_ack) begin
                n_fail++;
                $display("FAIL sb_dual_ack: both acks high");
            end else if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: ack ldr=%0b with empty queue",
                         ldr_ack);
            end else begin
                exp_t e;
                logic [31:0] got;
                e   = sb.pop_front();
                got = ldr_ack ? ldr_rdata : cpu_rdata;
                if (ldr_ack !== e.ldr || got !== e.d) begin
                    n_fail++;
                    $display("FAIL sb_ack: got ldr=%0b data %h want ldr=%0b data %h",
                             ldr_ack, got, e.ldr, e.d);
                end
            end
        end
    end

    // Starts at posedge+1 of cycle 0; ends at posedge+1 of the IDLE
    // cycle after ack with req dropped.
    task automatic run_single(logic ldr, logic we, logic [31:0] a,
                              logic [31:0] wd);
        if (ldr) begin
            ldr_we = we; ldr_addr = a; ldr_wdata = wd; ldr_req = 1'b1;
        end else begin
            cpu_we = we; cpu_addr = a; cpu_wdata = wd; cpu_req = 1'b1;
        end
        for (int c = 0; c <= WC + 1; c++) begin
            logic in_acc;
            in_acc = (c >= 1 && c <= WC);
            @(negedge CLK);
            chk("mem_en", 32'(mem_en), 32'(in_acc));
            if (in_acc) begin
                chk("mem_we", 32'(mem_we), 32'(we));
                chk("mem_addr", mem_addr, a);
                if (we) chk("mem_wdata", mem_wdata, wd);
            end
            chk("ack_timing", 32'(ldr ? ldr_ack : cpu_ack), 32'(c == WC + 1));
            if (!ldr) chk("cpu_stall", 32'(cpu_stall), 32'(c <= WC));
            @(posedge CLK); #1;
        end
        cpu_req = 1'b0;
        ldr_req = 1'b0;
    endtask

    initial begin
        RST = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = '0; ldr_wdata = '0;
        d15_cpu_req = 1'b0; d15_cpu_addr = '0; d15_cpu_wdata = '0;
        d15_mem_rdata = '0;

        repeat (2) @(negedge CLK);
        chk("rst_mem_en", 32'(mem_en), 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_acks", 32'({cpu_ack, ldr_ack}), 32'h0);
        chk("rst_cpu_rdata", cpu_rdata, 32'h0);
        chk("rst_ldr_rdata", ldr_rdata, 32'h0);
        @(posedge CLK); #1;
        RST = 1'b0;

        // Single CPU read
        expect_ack(1'b0, 32'hDEADBEEF);
        run_single(1'b0, 1'b0, 32'h10, 32'h0);
        chk("t1_cpu_rdata", cpu_rdata, 32'hDEADBEEF);

        // Loader write then CPU read of the same word
        expect_ack(1'b1, 32'h0);
        run_single(1'b1, 1'b1, 32'h20, 32'h12345678);
        expect_ack(1'b0, 32'h12345678);
        run_single(1'b0, 1'b0, 32'h20, 32'h0);
        chk("t2_cpu_rdata", cpu_rdata, 32'h12345678);
        chk("t2_ldr_rdata", ldr_rdata, 32'h0);

        // Simultaneous requests, fresh pointer
        RST = 1'b1;
        @(negedge CLK);
        chk("t3_rst_rdata", cpu_rdata, 32'h0);
        @(posedge CLK); #1;
        RST = 1'b0;
        cpu_acks = 0;
        ldr_acks = 0;
`ifdef ARB_ROUND_ROBIN_EN
        expect_ack(1'b0, 32'hDEADBEEF);
        expect_ack(1'b1, 32'h12345678);
        expect_ack(1'b0, 32'hDEADBEEF);
        expect_ack(1'b1, 32'h12345678);
`else
        for (int i = 0; i < 4; i++) expect_ack(1'b1, 32'h12345678);
`endif
        cpu_we = 1'b0; cpu_addr = 32'h10;
        ldr_we = 1'b0; ldr_addr = 32'h20;
        cpu_req = 1'b1; ldr_req = 1'b1;
        repeat (4 * (WC + 2)) @(posedge CLK);
        #1;
        cpu_req = 1'b0; ldr_req = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        chk("t3_cpu_acks", 32'(cpu_acks), 32'd2);
        chk("t3_ldr_acks", 32'(ldr_acks), 32'd2);
`else
        chk("t3_cpu_acks", 32'(cpu_acks), 32'd0);
        chk("t3_ldr_acks", 32'(ldr_acks), 32'd4);
`endif
        chk("t3_sb_drained", 32'(sb.size()), 32'd0);
        sb.delete();

        // Reset in the first ACCESS cycle of a CPU read
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        cpu_we = 1'b0; cpu_addr = 32'h10; cpu_req = 1'b1;
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("t4_pre_mem_en", 32'(mem_en), 32'h1);
        RST = 1'b1;
        #1;
        chk("t4_mem_en", 32'(mem_en), 32'h0);
        chk("t4_mem_addr", mem_addr, 32'h0);
        chk("t4_cpu_ack", 32'(cpu_ack), 32'h0);
        chk("t4_cpu_rdata", cpu_rdata, 32'h0);
        cpu_req = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        expect_ack(1'b0, 32'hDEADBEEF);
        run_single(1'b0, 1'b0, 32'h10, 32'h0);

        // Back-to-back CPU reads with req held; addr is junk outside IDLE
        expect_ack(1'b0, 32'hA1A1A1A1);
        expect_ack(1'b0, 32'hB2B2B2B2);
        expect_ack(1'b0, 32'hC3C3C3C3);
        cpu_we = 1'b0;
        cpu_req = 1'b1;
        for (int c = 0; c < 3 * (WC + 2); c++) begin
            int k;
            int p;
            k = c / (WC + 2);
            p = c % (WC + 2);
            cpu_addr = (p == 0) ? 32'h30 + 32'(4 * k) : 32'hFC;
            @(negedge CLK);
            if (p >= 1 && p <= WC)
                chk("t5_mem_addr", mem_addr, 32'h30 + 32'(4 * k));
            chk("t5_ack", 32'(cpu_ack), 32'(p == WC + 1));
            @(posedge CLK); #1;
        end
        cpu_req = 1'b0;
        chk("t5_sb_drained", 32'(sb.size()), 32'd0);

        // WAIT_CYC=15: latched address/data stable; capture on the 15th cycle
        d15_cpu_addr  = 32'h40;
        d15_cpu_wdata = 32'h5A5A5A5A;
        d15_mem_rdata = 32'hBAD0BAD0;
        d15_cpu_req   = 1'b1;
        for (int c = 0; c <= 16; c++) begin
            if (c > 0) begin
                d15_cpu_addr  = c[0] ? 32'h44 : 32'h48;
                d15_cpu_wdata = ~d15_cpu_wdata;
                d15_mem_rdata = (c == 15) ? 32'h15151515 : 32'hBAD0BAD0;
            end
            @(negedge CLK);
            if (c >= 1 && c <= 15) begin
                chk("t6_mem_en", 32'(d15_mem_en), 32'h1);
                chk("t6_mem_addr", d15_mem_addr, 32'h40);
                chk("t6_mem_wdata", d15_mem_wdata, 32'h5A5A5A5A);
            end
            chk("t6_ack", 32'(d15_cpu_ack), 32'(c == 16));
            chk("t6_stall", 32'(d15_cpu_stall), 32'(c != 16));
            if (c == 16) begin
                chk("t6_rdata", d15_cpu_rdata, 32'h15151515);
                chk("t6_mem_we", 32'(d15_mem_we), 32'h0);
                chk("t6_ldr", 32'(d15_ldr_ack) | d15_ldr_rdata, 32'h0);
            end
            @(posedge CLK); #1;
        end
        d15_cpu_req = 1'b0;

        repeat (2) @(posedge CLK);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences and shares the single unified instruction/data memory of the multicycle processor between two requesters: the CPU control path (instruction fetch and load/store) and a program loader/debug port. Each winning requester is granted one complete memory transaction of fixed latency. The arbiter drives the memory and returns a one-cycle acknowledge with read data. It produces a stall signal that freezes the multicycle controller's state register while a CPU access is outstanding.

## Interface
- ADDR_W, 32: address width.
- DATA_W, 32: data width.
- WAIT_CYC, 2: memory access cycles per transaction; legal range 1..15.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RST  in  1  reset; asynchronous, active-high.
- cpu_req  in  1  CPU requests one access; held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_W  registered read data; valid from cpu_ack onward.
- cpu_stall  out  1  combinational: cpu_req & ~cpu_ack.
- ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_ack, ldr_rdata  same directions, widths and meanings as the cpu_* ports, for the loader.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid in the last ACCESS cycle.

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- **IDLE**
  - If no request is pending: remain in IDLE.
  - Otherwise: select a winner, latch its we/addr/wdata into internal registers, set grant_id, load the wait counter with WAIT_CYC-1, and go to ACCESS.
- **ACCESS**
  - mem_en=1. mem_we, mem_addr and mem_wdata are driven from the latched registers and stay stable for the whole state.
  - The counter decrements each cycle. At 0, go to RESP.
  - For a read, mem_rdata is captured into the winner's rdata register on that final edge.
- **RESP**
  - The winner's ack=1 for exactly one cycle; mem_en=0.
  - Next state is always IDLE. A requester's req is not sampled again until IDLE.
- Writes: ack pulses; rdata keeps its previous value.
- A loser's request stays pending and is served in the next IDLE. It is never dropped.
- Dropping req before ack is illegal. If it happens, the arbiter still completes the transaction and still pulses ack.
- A req still high in the IDLE following ack counts as a new request.
- Reset, at any time including mid-ACCESS:
  - Go to IDLE and abandon any transaction.
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - cpu_ack=0, ldr_ack=0, cpu_rdata=0, ldr_rdata=0.
  - Priority pointer reset to "last grant = loader".

## Timing
- Latency: request seen in IDLE on cycle 0 → ACCESS on cycles 1..WAIT_CYC → ack on cycle WAIT_CYC+1 → IDLE on cycle WAIT_CYC+2.
- Throughput: one transaction per WAIT_CYC+2 cycles.
- All outputs are registered except cpu_stall.
- cpu_stall is high from the first cycle of cpu_req through the cycle before cpu_ack. It is low in the ack cycle, so the controller advances exactly on ack.
- mem_* change only on the IDLE→ACCESS edge and the ACCESS→RESP edge.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - Simultaneous requests in IDLE are granted to the requester not granted last.
  - The pointer updates on every grant.
  - Starvation-free; after reset the CPU wins the first tie.
- Undefined:
  - Fixed priority, loader over CPU; the pointer logic is absent.
  - With ldr_req held continuously, the CPU is starved, which is intended for program load while the core is stalled.

## Test plan
- **Single CPU read.** WAIT_CYC=2, memory word 0x10 = 0xDEADBEEF, cpu_req with addr 0x10 at cycle 0 → mem_en high on cycles 1-2, cpu_ack on cycle 3, cpu_rdata = 0xDEADBEEF, cpu_stall high on cycles 0-2.
- **Loader write then CPU read.** ldr write 0x1234_5678 to 0x20, then CPU read 0x20 → mem_we high during the loader ACCESS only; cpu_rdata = 0x12345678; ldr_rdata unchanged.
- **Simultaneous requests.** Both reqs held, 4 transactions:
  - Round-robin build: grant order CPU, LDR, CPU, LDR.
  - Fixed build: LDR every time, cpu_ack never pulses.
- **Reset mid-ACCESS.** Assert RST on cycle 1 of a CPU read → mem_en=0 and the FSM is in IDLE immediately. cpu_ack is never pulsed; cpu_rdata = 0. Re-issue after release → normal completion WAIT_CYC+1 cycles later.
- **Back-to-back CPU reads.** cpu_req held high through 3 reads, WAIT_CYC=1 → ack on cycles 2, 5, 8; addr changes are accepted only at IDLE.
- **WAIT_CYC=15 stability.** mem_addr/mem_wdata are constant for 15 ACCESS cycles while the requester's addr toggles; rdata is captured on the 15th cycle.
